// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell and winner codes, sequencer states,
// the win-line table and small board helpers used by turn_sequencer.
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam int BOARD_W   = 2 * NUM_CELLS;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    CHECK,
    OVER
  } state_t;

  // Three rows, three columns, two diagonals; each entry is a cell-index triplet.
  localparam logic [7:0][2:0][3:0] WIN_LINES = {
    4'd0, 4'd1, 4'd2,
    4'd3, 4'd4, 4'd5,
    4'd6, 4'd7, 4'd8,
    4'd0, 4'd3, 4'd6,
    4'd1, 4'd4, 4'd7,
    4'd2, 4'd5, 4'd8,
    4'd0, 4'd4, 4'd8,
    4'd2, 4'd4, 4'd6
  };

  function automatic logic has_line(input logic [BOARD_W-1:0] b, input logic [1:0] m);
    logic found;
    found = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((b[2*WIN_LINES[l][0] +: 2] == m) &&
          (b[2*WIN_LINES[l][1] +: 2] == m) &&
          (b[2*WIN_LINES[l][2] +: 2] == m)) begin
        found = 1'b1;
      end
    end
    return found;
  endfunction

  function automatic logic board_full(input logic [BOARD_W-1:0] b);
    logic full;
    full = 1'b1;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (b[2*k +: 2] == EMPTY) begin
        full = 1'b0;
      end
    end
    return full;
  endfunction

  // Out-of-range indices are never free, which also keeps the slice in bounds.
  function automatic logic cell_free(input logic [BOARD_W-1:0] b, input logic [3:0] c);
    logic free;
    free = 1'b0;
    if (c < 4'(NUM_CELLS)) begin
      free = (b[2*c +: 2] == EMPTY);
    end
    return free;
  endfunction

endpackage

// File: rtl/turn_tick_gen.sv
// Turn timer: prescaler producing one tick per TICK_DIV cycles plus a down-counter
// of ticks left in the turn. Built only when TURN_TIMEOUT_EN is defined.
`ifdef TURN_TIMEOUT_EN
module turn_tick_gen #(
  parameter int TICK_DIV   = 100000000,
  parameter int TURN_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       reload,
  output logic [7:0] time_left,
  output logic       expire
);

  localparam int             PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    time_q, time_d;
  logic          tick;

  assign tick      = run && (presc_q == TERM);
  assign expire    = tick && (time_q == 8'd1);
  assign time_left = time_q;

  // Reload beats counting so a forfeited turn restarts from a clean prescaler.
  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    if (reload) begin
      presc_d = '0;
      time_d  = 8'(TURN_TICKS);
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        time_d = time_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

endmodule
`endif

// File: rtl/turn_sequencer.sv
// Two-player tic-tac-toe sequencer: owns the board, arbitrates moves, detects win/draw.
// Optional turn timer is enabled by defining TURN_TIMEOUT_EN.
module turn_sequencer
  import ttt_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int TURN_TICKS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_game,
  input  logic [1:0]   req,
  input  logic [3:0]   cell0,
  input  logic [3:0]   cell1,
  output logic [1:0]   ack,
  output logic [1:0]   nack,
  output logic [17:0]  board,
  output logic         turn,
  output logic [1:0]   winner,
  output logic         game_over,
  output logic [7:0]   time_left,
  output logic         timeout
);

  state_t              state_q, state_d;
  logic [BOARD_W-1:0]  board_q, board_d;
  logic                turn_q, turn_d;
  logic [1:0]          winner_q, winner_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          nack_q, nack_d;
  logic                timeout_q, timeout_d;

  logic [1:0]          legal;
  logic [3:0]          curCell;
  logic                accept;
  logic                expire;
  logic                reloadTimer;

  assign legal[0] = cell_free(board_q, cell0);
  assign legal[1] = cell_free(board_q, cell1);
  assign curCell  = turn_q ? cell1 : cell0;
  assign accept   = (state_q == TURN) && req[turn_q] && legal[turn_q];

  // new_game overrides everything; otherwise each player's request is answered
  // independently and the state machine advances.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    ack_d       = 2'b00;
    nack_d      = 2'b00;
    timeout_d   = 1'b0;
    reloadTimer = 1'b0;

    if (new_game) begin
      board_d     = '0;
      turn_d      = 1'b0;
      winner_d    = WIN_NONE;
      state_d     = TURN;
      reloadTimer = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (req[p]) begin
          if ((state_q == TURN) && (turn_q == 1'(p)) && legal[p]) begin
            ack_d[p] = 1'b1;
          end else begin
            nack_d[p] = 1'b1;
          end
        end
      end

      unique case (state_q)
        IDLE: ;
        TURN: begin
          if (accept) begin
            board_d[2*curCell +: 2] = turn_q ? MARK_O : MARK_X;
            state_d = CHECK;
          end else if (expire) begin
            timeout_d   = 1'b1;
            turn_d      = ~turn_q;
            reloadTimer = 1'b1;
          end
        end
        CHECK: begin
          if (has_line(board_q, MARK_X)) begin
            winner_d = WIN_X;
            state_d  = OVER;
          end else if (has_line(board_q, MARK_O)) begin
            winner_d = WIN_O;
            state_d  = OVER;
          end else if (board_full(board_q)) begin
            winner_d = WIN_DRAW;
            state_d  = OVER;
          end else begin
            turn_d      = ~turn_q;
            reloadTimer = 1'b1;
            state_d     = TURN;
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      board_q   <= '0;
      turn_q    <= 1'b0;
      winner_q  <= WIN_NONE;
      ack_q     <= 2'b00;
      nack_q    <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef TURN_TIMEOUT_EN
  // An accepted move freezes the timer, so a move on the expiring tick wins.
  logic runTimer;
  assign runTimer = (state_q == TURN) && !new_game && !accept;

  turn_tick_gen #(
    .TICK_DIV   (TICK_DIV),
    .TURN_TICKS (TURN_TICKS)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .run       (runTimer),
    .reload    (reloadTimer),
    .time_left (time_left),
    .expire    (expire)
  );
`else
  logic unusedCfg;
  assign expire    = 1'b0;
  assign time_left = '0;
  assign unusedCfg = reloadTimer ^ (TICK_DIV > 1) ^ (TURN_TICKS > 0);
`endif

  assign ack       = ack_q;
  assign nack      = nack_q;
  assign board     = board_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = (state_q == OVER);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: table-driven game vectors through a
// scoreboard queue, plus hand sequences for timer, same-cycle and reset corners.
module tb_turn_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int TURN_TICKS = 3;

  localparam logic [1:0] X_MARK = 2'b01;
  localparam logic [1:0] O_MARK = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic [1:0]  req;
  logic [3:0]  cell0;
  logic [3:0]  cell1;
  logic [1:0]  ack;
  logic [1:0]  nack;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  winner;
  logic        game_over;
  logic [7:0]  time_left;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ng;
    logic [1:0]  req;
    logic [3:0]  c0;
    logic [3:0]  c1;
    logic [1:0]  ack;
    logic [1:0]  nack;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  winner;
    logic        over;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  turn_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .TURN_TICKS (TURN_TICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .new_game  (new_game),
    .req       (req),
    .cell0     (cell0),
    .cell1     (cell1),
    .ack       (ack),
    .nack      (nack),
    .board     (board),
    .turn      (turn),
    .winner    (winner),
    .game_over (game_over),
    .time_left (time_left),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] put(input logic [17:0] b, input int k, input logic [1:0] m);
    logic [17:0] r;
    r = b;
    r[2*k +: 2] = m;
    return r;
  endfunction

  task automatic addVec(input logic ng, input logic [1:0] rq, input logic [3:0] c0,
                        input logic [3:0] c1, input logic [1:0] a, input logic [1:0] n,
                        input logic [17:0] b, input logic t, input logic [1:0] w,
                        input logic o);
    vec_t v;
    v.ng = ng; v.req = rq; v.c0 = c0; v.c1 = c1;
    v.ack = a; v.nack = n; v.board = b; v.turn = t; v.winner = w; v.over = o;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    new_game = v.ng;
    req      = v.req;
    cell0    = v.c0;
    cell1    = v.c1;
    sb.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".ack"},       32'(ack),       32'(e.ack));
      cmp({tag, ".nack"},      32'(nack),      32'(e.nack));
      cmp({tag, ".board"},     32'(board),     32'(e.board));
      cmp({tag, ".turn"},      32'(turn),      32'(e.turn));
      cmp({tag, ".winner"},    32'(winner),    32'(e.winner));
      cmp({tag, ".game_over"}, 32'(game_over), 32'(e.over));
      cmp({tag, ".timeout"},   32'(timeout),   32'd0);
    end
  endtask

  task automatic stepIdle(input int n);
    @(negedge clk);
    new_game = 1'b0;
    req      = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] b;
    int          drawSeq [9];
    vec_t        v;
    logic        p;

    rst = 1'b1; new_game = 1'b0; req = 2'b00; cell0 = 4'd0; cell1 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset.board",     32'(board),     32'd0);
    cmp("reset.turn",      32'(turn),      32'd0);
    cmp("reset.winner",    32'(winner),    32'd0);
    cmp("reset.game_over", 32'(game_over), 32'd0);
    cmp("reset.ack",       32'(ack),       32'd0);
    cmp("reset.nack",      32'(nack),      32'd0);
    cmp("reset.time_left", 32'(time_left), 32'd0);
    cmp("reset.timeout",   32'(timeout),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Game 1: IDLE nack, accept, occupied/out-of-range/wrong-player rejects.
    addVec(0, 2'b01, 4, 0, 2'b00, 2'b01, 18'h0, 0, 2'b00, 0);
    addVec(1, 2'b00, 0, 0, 2'b00, 2'b00, 18'h0, 0, 2'b00, 0);
    b = put(18'h0, 4, X_MARK);
    addVec(0, 2'b01, 4, 0, 2'b01, 2'b00, b, 0, 2'b00, 0);
    addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, 1, 2'b00, 0);
    addVec(0, 2'b10, 0, 4, 2'b00, 2'b10, b, 1, 2'b00, 0);
    addVec(0, 2'b10, 0, 9, 2'b00, 2'b10, b, 1, 2'b00, 0);
    addVec(0, 2'b01, 0, 0, 2'b00, 2'b01, b, 1, 2'b00, 0);
    b = put(b, 0, O_MARK);
    addVec(0, 2'b11, 0, 0, 2'b10, 2'b01, b, 1, 2'b00, 0);
    addVec(0, 2'b01, 1, 0, 2'b00, 2'b01, b, 0, 2'b00, 0);

    // Game 2: new_game with a same-cycle request, then X wins on the top row.
    addVec(1, 2'b01, 3, 0, 2'b00, 2'b00, 18'h0, 0, 2'b00, 0);
    b = put(18'h0, 0, X_MARK);
    addVec(0, 2'b01, 0, 0, 2'b01, 2'b00, b, 0, 2'b00, 0);
    addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, 1, 2'b00, 0);
    b = put(b, 3, O_MARK);
    addVec(0, 2'b10, 0, 3, 2'b10, 2'b00, b, 1, 2'b00, 0);
    addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, 0, 2'b00, 0);
    b = put(b, 1, X_MARK);
    addVec(0, 2'b01, 1, 0, 2'b01, 2'b00, b, 0, 2'b00, 0);
    addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, 1, 2'b00, 0);
    b = put(b, 4, O_MARK);
    addVec(0, 2'b10, 0, 4, 2'b10, 2'b00, b, 1, 2'b00, 0);
    addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, 0, 2'b00, 0);
    b = put(b, 2, X_MARK);
    addVec(0, 2'b01, 2, 0, 2'b01, 2'b00, b, 0, 2'b00, 0);
    addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, 0, 2'b01, 1);
    addVec(0, 2'b11, 5, 5, 2'b00, 2'b11, b, 0, 2'b01, 1);

    // Game 3: full board without a line ends in a draw.
    addVec(1, 2'b00, 0, 0, 2'b00, 2'b00, 18'h0, 0, 2'b00, 0);
    drawSeq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    b = 18'h0;
    for (int i = 0; i < 9; i++) begin
      p = 1'(i % 2);
      b = put(b, drawSeq[i], p ? O_MARK : X_MARK);
      addVec(0, p ? 2'b10 : 2'b01, 4'(drawSeq[i]), 4'(drawSeq[i]),
             p ? 2'b10 : 2'b01, 2'b00, b, p, 2'b00, 0);
      if (i < 8) addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, ~p, 2'b00, 0);
      else       addVec(0, 2'b00, 0, 0, 2'b00, 2'b00, b, 1'b0, 2'b11, 1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d", i));
    end

    // Asynchronous reset mid-game clears state before the next clock edge.
    @(negedge clk);
    new_game = 1'b0; req = 2'b00;
    #2 rst = 1'b1;
    #1;
    cmp("async_rst.board",     32'(board),     32'd0);
    cmp("async_rst.winner",    32'(winner),    32'd0);
    cmp("async_rst.game_over", 32'(game_over), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    v.ng = 1; v.req = 2'b00; v.c0 = 0; v.c1 = 0; v.ack = 2'b00; v.nack = 2'b00;
    v.board = 18'h0; v.turn = 0; v.winner = 2'b00; v.over = 0;
    applyStimulus(v);
    checkOutput("timer_start");
`ifdef TURN_TIMEOUT_EN
    cmp("timer_start.time_left", 32'(time_left), 32'd3);
    stepIdle(4);
    cmp("tick1.time_left", 32'(time_left), 32'd2);
    stepIdle(7);
    cmp("pre_expire.time_left", 32'(time_left), 32'd1);
    cmp("pre_expire.timeout",   32'(timeout),   32'd0);
    cmp("pre_expire.turn",      32'(turn),      32'd0);
    stepIdle(1);
    cmp("expire.timeout",   32'(timeout),   32'd1);
    cmp("expire.turn",      32'(turn),      32'd1);
    cmp("expire.time_left", 32'(time_left), 32'd3);
    stepIdle(1);
    cmp("post_expire.timeout", 32'(timeout), 32'd0);
    stepIdle(10);
    cmp("pre_expire2.time_left", 32'(time_left), 32'd1);
    v.ng = 0; v.req = 2'b10; v.c0 = 0; v.c1 = 0; v.ack = 2'b10; v.nack = 2'b00;
    v.board = put(18'h0, 0, O_MARK); v.turn = 1; v.winner = 2'b00; v.over = 0;
    applyStimulus(v);
    checkOutput("move_on_expire");
    stepIdle(1);
    cmp("move_on_expire.next_turn",  32'(turn),      32'd0);
    cmp("move_on_expire.time_left",  32'(time_left), 32'd3);
    cmp("move_on_expire.no_timeout", 32'(timeout),   32'd0);
`else
    cmp("timer_start.time_left", 32'(time_left), 32'd0);
    stepIdle(12);
    cmp("no_timer.timeout",   32'(timeout),   32'd0);
    cmp("no_timer.turn",      32'(turn),      32'd0);
    cmp("no_timer.time_left", 32'(time_left), 32'd0);
    stepIdle(12);
    cmp("no_timer.turn_late", 32'(turn),      32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
